// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants, default widths and arbiter state types.
package alu_pkg;

    localparam int unsigned ALU_W   = 32;
    localparam int unsigned ALU_OPW = 4;

    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_CMP    = 4'b0001;
    localparam logic [3:0] ALU_AND    = 4'b0010;
    localparam logic [3:0] ALU_XOR    = 4'b0011;
    localparam logic [3:0] ALU_SLL    = 4'b0100;
    localparam logic [3:0] ALU_SRL    = 4'b0101;
    localparam logic [3:0] ALU_SRA    = 4'b0110;
    localparam logic [3:0] ALU_DIFF   = 4'b0111;
    // Bit 3 of the opcode selects the register shift amount instead of shamt.
    localparam logic [3:0] ALU_VAR_SH = 4'b1000;

    typedef enum logic [1:0] {
        LOCK_NONE = 2'b00,
        LOCK_P0   = 2'b01,
        LOCK_P1   = 2'b10
    } lock_e;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'b00,
        GRANT_P0   = 2'b01,
        GRANT_P1   = 2'b10
    } grant_e;

endpackage

// File: rtl/arb_pick2.sv
// Combinational two-way grant from eligibility, lock owner and last-served pointer.
// ALU_ARB_RR_EN selects round-robin contention handling; otherwise port 0 has fixed priority.
module arb_pick2
    import alu_pkg::*;
(
    input  logic [1:0] elig,
    input  lock_e      lock,
`ifdef ALU_ARB_RR_EN
    input  logic       last,
`endif
    output grant_e     grant
);

    always_comb begin
        grant = GRANT_NONE;
        if (lock == LOCK_P0 && elig[0]) begin
            grant = GRANT_P0;
        end else if (lock == LOCK_P1 && elig[1]) begin
            grant = GRANT_P1;
        end else if (elig == 2'b11) begin
`ifdef ALU_ARB_RR_EN
            grant = last ? GRANT_P0 : GRANT_P1;
`else
            grant = GRANT_P0;
`endif
        end else if (elig[0]) begin
            grant = GRANT_P0;
        end else if (elig[1]) begin
            grant = GRANT_P1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares the execute-stage ALU between two requesters and holds one result per port.
// Define ALU_ARB_RR_EN for round-robin arbitration; default build uses fixed priority.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned W   = ALU_W,
    parameter int unsigned OPW = ALU_OPW
) (
    input  logic           clk,
    input  logic           rst,

    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [W-1:0]   req0_a,
    input  logic [W-1:0]   req0_b,
    input  logic [4:0]     req0_shamt,
    input  logic [OPW-1:0] req0_op,
    input  logic           req0_lock,

    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [W-1:0]   req1_a,
    input  logic [W-1:0]   req1_b,
    input  logic [4:0]     req1_shamt,
    input  logic [OPW-1:0] req1_op,
    input  logic           req1_lock,

    output logic           resp0_valid,
    input  logic           resp0_ready,
    output logic [W-1:0]   resp0_result,
    output logic           resp0_carry,

    output logic           resp1_valid,
    input  logic           resp1_ready,
    output logic [W-1:0]   resp1_result,
    output logic           resp1_carry,

    output logic [W-1:0]   alu_in1,
    output logic [W-1:0]   alu_in2,
    output logic [4:0]     alu_shamt,
    output logic [OPW-1:0] alu_op,
    input  logic [W-1:0]   alu_out,
    input  logic           alu_carry
);

    logic       free0;
    logic       free1;
    logic [1:0] elig;
    logic       acc0;
    logic       acc1;
    grant_e     grant;
    lock_e      lock_q;

    assign free0 = !resp0_valid || resp0_ready;
    assign free1 = !resp1_valid || resp1_ready;
    assign elig  = {req1_valid && free1, req0_valid && free0} & {2{!rst}};

`ifdef ALU_ARB_RR_EN
    logic last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (acc0) begin
            last_q <= 1'b0;
        end else if (acc1) begin
            last_q <= 1'b1;
        end
    end

    arb_pick2 u_pick (
        .elig  (elig),
        .lock  (lock_q),
        .last  (last_q),
        .grant (grant)
    );
`else
    arb_pick2 u_pick (
        .elig  (elig),
        .lock  (lock_q),
        .grant (grant)
    );
`endif

    assign acc0       = (grant == GRANT_P0);
    assign acc1       = (grant == GRANT_P1);
    assign req0_ready = acc0;
    assign req1_ready = acc1;

    always_comb begin
        alu_in1   = '0;
        alu_in2   = '0;
        alu_shamt = '0;
        alu_op    = '0;
        if (acc0) begin
            alu_in1   = req0_a;
            alu_in2   = req0_b;
            alu_shamt = req0_shamt;
            alu_op    = req0_op;
        end else if (acc1) begin
            alu_in1   = req1_a;
            alu_in2   = req1_b;
            alu_shamt = req1_shamt;
            alu_op    = req1_op;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp0_valid  <= 1'b0;
            resp0_result <= '0;
            resp0_carry  <= 1'b0;
        end else if (acc0) begin
            resp0_valid  <= 1'b1;
            resp0_result <= alu_out;
            resp0_carry  <= alu_carry;
        end else if (resp0_ready) begin
            resp0_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp1_valid  <= 1'b0;
            resp1_result <= '0;
            resp1_carry  <= 1'b0;
        end else if (acc1) begin
            resp1_valid  <= 1'b1;
            resp1_result <= alu_out;
            resp1_carry  <= alu_carry;
        end else if (resp1_ready) begin
            resp1_valid  <= 1'b0;
        end
    end

    // A cycle without any accept means no port was eligible, including a locked one,
    // so the lock always drops then; an accept re-arms it only for the accepting port.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q <= LOCK_NONE;
        end else if (acc0) begin
            lock_q <= req0_lock ? LOCK_P0 : LOCK_NONE;
        end else if (acc1) begin
            lock_q <= req1_lock ? LOCK_P1 : LOCK_NONE;
        end else begin
            lock_q <= LOCK_NONE;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios then randomized traffic vs a reference model.
// Expectations follow ALU_ARB_RR_EN in the same way as the design build.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [4:0]  req0_shamt, req1_shamt;
    logic [3:0]  req0_op, req1_op;
    logic        req0_lock, req1_lock;
    logic        resp0_valid, resp1_valid, resp0_ready, resp1_ready;
    logic [31:0] resp0_result, resp1_result;
    logic        resp0_carry, resp1_carry;
    logic [31:0] alu_in1, alu_in2, alu_out;
    logic [4:0]  alu_shamt;
    logic [3:0]  alu_op;
    logic        alu_carry;

    // Request fields driven by the stimulus
    logic        v[2], lk[2], rr[2];
    logic [31:0] a[2], b[2];
    logic [4:0]  sh[2];
    logic [3:0]  op[2];

    // Reference model state
    logic        m_valid[2];
    logic [31:0] m_res[2];
    logic        m_carry[2];
    int          m_lock;
    int          m_last;
    logic        stalled[2];

    int checks = 0;
    int errors = 0;
    int dut_g;
    int hist[4];

    always #5 clk = ~clk;

    assign req0_valid = v[0];  assign req1_valid = v[1];
    assign req0_a = a[0];      assign req1_a = a[1];
    assign req0_b = b[0];      assign req1_b = b[1];
    assign req0_shamt = sh[0]; assign req1_shamt = sh[1];
    assign req0_op = op[0];    assign req1_op = op[1];
    assign req0_lock = lk[0];  assign req1_lock = lk[1];
    assign resp0_ready = rr[0]; assign resp1_ready = rr[1];

    function automatic logic [32:0] alu_f(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                          input logic [4:0] s_imm);
        logic [4:0]  s;
        logic [31:0] t;
        s = o[3] ? y[4:0] : s_imm;
        case (o[2:0])
            3'd0: return {1'b0, x} + {1'b0, y};
            3'd1: return {32'd0, (x < y)};
            3'd2: return {1'b0, x & y};
            3'd3: return {1'b0, x ^ y};
            3'd4: return {1'b0, x << s};
            3'd5: return {1'b0, x >> s};
            3'd6: begin t = $signed(x) >>> s; return {1'b0, t}; end
            default: return {1'b0, (x > y) ? x - y : y - x};
        endcase
    endfunction

    // Behavioural ALU the arbiter is wired to
    assign {alu_carry, alu_out} = alu_f(alu_op, alu_in1, alu_in2, alu_shamt);

    alu_arbiter #(.W(32), .OPW(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_shamt(req0_shamt), .req0_op(req0_op), .req0_lock(req0_lock),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_shamt(req1_shamt), .req1_op(req1_op), .req1_lock(req1_lock),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_result(resp0_result),
        .resp0_carry(resp0_carry),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_result(resp1_result),
        .resp1_carry(resp1_carry),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_shamt(alu_shamt), .alu_op(alu_op),
        .alu_out(alu_out), .alu_carry(alu_carry)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Which port should win this cycle, from the arbitration rules
    function automatic int predict();
        logic e[2];
        for (int n = 0; n < 2; n++)
            e[n] = v[n] && (!m_valid[n] || rr[n]) && !rst;
        if (m_lock >= 0 && e[m_lock]) return m_lock;
        if (e[0] && e[1]) begin
`ifdef ALU_ARB_RR_EN
            return (m_last == 0) ? 1 : 0;
`else
            return 0;
`endif
        end
        if (e[0]) return 0;
        if (e[1]) return 1;
        return -1;
    endfunction

    // One clock: called at negedge with inputs set; returns at the following negedge
    task automatic cycle();
        int          g;
        logic [32:0] r;
        g = predict();
        #1;
        dut_g = req0_ready ? 0 : (req1_ready ? 1 : -1);
        chk("req0_ready", req0_ready, g == 0);
        chk("req1_ready", req1_ready, g == 1);
        chk("alu_in1", alu_in1, (g == 0) ? a[0] : (g == 1) ? a[1] : 32'd0);
        chk("alu_op", alu_op, (g == 0) ? op[0] : (g == 1) ? op[1] : 4'd0);
        @(posedge clk);
        for (int n = 0; n < 2; n++)
            stalled[n] = v[n] && (g != n);
        if (rst) begin
            for (int n = 0; n < 2; n++) begin
                m_valid[n] = 1'b0; m_res[n] = '0; m_carry[n] = 1'b0;
            end
            m_lock = -1;
            m_last = 1;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (g == n) begin
                    r = alu_f(op[n], a[n], b[n], sh[n]);
                    m_valid[n] = 1'b1; m_res[n] = r[31:0]; m_carry[n] = r[32];
                end else if (rr[n] && m_valid[n]) begin
                    m_valid[n] = 1'b0;
                end
            end
            m_lock = (g >= 0 && lk[g]) ? g : -1;
            if (g >= 0) m_last = g;
        end
        #1;
        chk("resp0_valid", resp0_valid, m_valid[0]);
        chk("resp1_valid", resp1_valid, m_valid[1]);
        chk("resp0_result", resp0_result, m_res[0]);
        chk("resp1_result", resp1_result, m_res[1]);
        chk("resp0_carry", resp0_carry, m_carry[0]);
        chk("resp1_carry", resp1_carry, m_carry[1]);
        @(negedge clk);
    endtask

    initial begin
        int exp_g;
        rst = 1'b1;
        for (int n = 0; n < 2; n++) begin
            v[n] = 1'b1; lk[n] = 1'b0; rr[n] = 1'b1;
            a[n] = 32'd3; b[n] = 32'd4; sh[n] = '0; op[n] = 4'd0;
            m_valid[n] = 1'b0; m_res[n] = '0; m_carry[n] = 1'b0; stalled[n] = 1'b0;
        end
        m_lock = -1;
        m_last = 1;
        @(negedge clk);

        // Reset with both requesting: no readies
        cycle();
        cycle();
        chk("reset_ready", dut_g, -1);

        // Port 0 only: 5 + 7
        rst = 1'b0;
        v[1] = 1'b0;
        a[0] = 32'd5; b[0] = 32'd7; op[0] = 4'b0000;
        cycle();
        chk("p0_add_valid", resp0_valid, 1'b1);
        chk("p0_add_result", resp0_result, 32'd12);
        chk("p0_add_carry", resp0_carry, 1'b0);
        v[0] = 1'b0;
        cycle();

        // Carry out on port 1, then AND of the same operands
        v[1] = 1'b1; a[1] = 32'hFFFF_FFFF; b[1] = 32'd1; op[1] = 4'b0000;
        cycle();
        chk("p1_carry_result", resp1_result, 32'd0);
        chk("p1_carry_carry", resp1_carry, 1'b1);
        op[1] = 4'b0010;
        cycle();
        chk("p1_and_result", resp1_result, 32'd1);
        chk("p1_and_carry", resp1_carry, 1'b0);

        // Contention for four cycles
        v[0] = 1'b1; v[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a[0] = $urandom; b[0] = $urandom; a[1] = $urandom; b[1] = $urandom;
            op[0] = 4'd0; op[1] = 4'd3;
            cycle();
            hist[i] = dut_g;
        end
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_RR_EN
            exp_g = i % 2;
`else
            exp_g = 0;
`endif
            chk("contend_grant", hist[i], exp_g);
        end

        // Backpressure on port 0, then drain and refill together
        v[1] = 1'b0;
        cycle();
        v[1] = 1'b1; rr[0] = 1'b0;
        cycle();
        chk("bp_serves_p1", dut_g, 1);
        rr[0] = 1'b1; a[0] = 32'd100; b[0] = 32'd23; op[0] = 4'd0;
        cycle();
        chk("bp_refill_grant", dut_g, 0);
        chk("bp_refill_result", resp0_result, 32'd123);

        // Lock held by port 1 while port 0 waits
        rr[0] = 1'b0; lk[1] = 1'b1;
        cycle();
        chk("lock_first", dut_g, 1);
        rr[0] = 1'b1; lk[1] = 1'b0;
        cycle();
        chk("lock_hold", dut_g, 1);
        v[1] = 1'b0;
        cycle();
        chk("lock_release", dut_g, 0);

        // Reset right after an accept
        cycle();
        rst = 1'b1; v[1] = 1'b1;
        cycle();
        chk("rst_ready", dut_g, -1);
        chk("rst_resp0_valid", resp0_valid, 1'b0);
        rst = 1'b0;
        cycle();
        chk("post_rst_grant", dut_g, 0);

        // Randomized traffic; stalled requests hold their fields
        for (int i = 0; i < 400; i++) begin
            for (int n = 0; n < 2; n++) begin
                if (!stalled[n]) begin
                    v[n]  = ($urandom_range(0, 3) != 0);
                    a[n]  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
                    b[n]  = $urandom;
                    sh[n] = 5'($urandom_range(0, 31));
                    op[n] = 4'($urandom_range(0, 15));
                    lk[n] = ($urandom_range(0, 3) == 0);
                end
                rr[n] = ($urandom_range(0, 3) != 0);
            end
            rst = ($urandom_range(0, 49) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single execute-stage `alu` between two requesters: port 0 (main pipeline execute) and port 1 (multi-cycle helper, e.g. address/compare sequencer). The block:
- grants the ALU to one requester per cycle;
- drives the ALU operands and opcode combinationally;
- captures `outreg` and `carry` into a per-port response register, held until the requester accepts it.

It sits between the pipeline control and the ALU instance in the execute stage.

## Interface
Parameters:
- `W`, 32, operand/result width (must equal ALU width)
- `OPW`, 4, ALU opcode width

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `reqN_valid`  in  1  request N valid (N = 0, 1)
- `reqN_ready`  out  1  request N accepted this cycle when high with `reqN_valid`
- `reqN_a`, `reqN_b`  in  W  operands
- `reqN_shamt`  in  5  immediate shift amount
- `reqN_op`  in  OPW  ALU opcode
- `reqN_lock`  in  1  keep grant on N for the next cycle
- `respN_valid`  out  1  result N available
- `respN_ready`  in  1  requester N takes result
- `respN_result`  out  W  captured `outreg`
- `respN_carry`  out  1  captured `carry`
- `alu_in1`, `alu_in2`  out  W  to ALU `inreg_1`/`inreg_2`
- `alu_shamt`  out  5  to ALU `shamt`
- `alu_op`  out  OPW  to ALU `alu_op`
- `alu_out`  in  W  from ALU `outreg`
- `alu_carry`  in  1  from ALU `carry`

## Operation
- Slot N is free when `!respN_valid || respN_ready` (drain and refill in the same cycle is allowed).
- Port N is eligible when `reqN_valid && slotN free`.
- Grant rule:
  - If a lock is held by port L and L is eligible, grant L.
  - Otherwise grant by policy (see Configuration). Only eligible ports are considered.
  - If no port is eligible, grant none.
- `reqN_ready` = granted to N. It is combinational from valids, slot state, lock and pointer, and never depends on `alu_out`.
- ALU mux:
  - Granted port's `a`/`b`/`shamt`/`op` drive the ALU.
  - With no grant, the ALU inputs are driven to 0 and `op` = 4'b0000 (add).
- On accept by N: `respN_result` <= `alu_out`, `respN_carry` <= `alu_carry`, `respN_valid` <= 1.
- On `respN_ready && respN_valid` with no new accept: `respN_valid` <= 0. Data holds its last value.
- Lock register:
  - Set to port N on an accept with `reqN_lock` = 1.
  - Cleared on an accept with lock = 0.
  - Cleared if the locked port is not eligible in a cycle, so a lock never stalls the other port.
- Round-robin pointer `last`: updated to the granted port on every accept; unchanged otherwise.
- Opcodes pass through unmodified. The ALU decodes them (bit3 selects register vs immediate shift amount). `carry` is meaningful only for op[2:0] = 000.

## Timing
- Request-to-response latency: 1 cycle. Accept in cycle T gives `respN_valid` = 1 from cycle T+1.
- Throughput: one accepted request per cycle total, across both ports.
- Reset values, applied on the edge with `rst` = 1:
  - `resp0_valid` = `resp1_valid` = 0
  - results = 0, carries = 0
  - lock = none
  - `last` = 1, so port 0 wins the first contention
- `reqN_ready` = 0 whenever `rst` is high.
- Reset during an outstanding response discards it; no response is produced after reset deasserts.
- A request that is stalled (valid but not ready) must hold its fields stable. The arbiter does not latch operands.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin policy. On contention, the port ≠ `last` wins.
- `ALU_ARB_RR_EN` undefined: fixed priority. Port 0 always wins contention; the `last` register is not built.
- Lock behaviour is identical in both builds.

## Structure
- Shared package `alu_pkg` holds:
  - opcode constants (`ALU_ADD`=0000, `ALU_CMP`=0001, `ALU_AND`=0010, `ALU_XOR`=0011, `ALU_SLL`=0100, `ALU_SRL`=0101, `ALU_SRA`=0110, `ALU_DIFF`=0111, `ALU_VAR_SH`=bit3)
  - `W`/`OPW` defaults
- One sub-module, `arb_pick2`: combinational 2-way grant from eligible, lock and `last` (policy selected by the macro).
- Response registers, pointer and lock live in the top module.

## Test plan
- Port 0 only: `a`=5, `b`=7, op 0000 → `resp0_valid` next cycle, result 12, carry 0; `req1_ready` stays 0.
- Carry: `a`=0xFFFFFFFF, `b`=1, op 0000 on port 1 → result 0, carry 1. Op 0010 with the same operands → result 1, carry 0.
- Both valid for 4 cycles, responses always ready:
  - RR build grants 0,1,0,1.
  - Fixed build grants 0,0,0,0.
  - Each result matches its own operands.
- Backpressure: `resp0_ready` = 0 with `resp0_valid` = 1 → `req0_ready` = 0 and port 1 is served. Raising `resp0_ready` drains and refills port 0 in the same cycle.
- Lock: port 1 accepts with lock = 1 while port 0 is valid → port 1 is granted again next cycle. When port 1 drops valid, port 0 is granted that cycle.
- Reset mid-flight: `rst` asserted the cycle after an accept → `resp*_valid` = 0 and all readies = 0. After release, port 0 wins first contention.
